// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with valid/ready input and internal bit timing
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/lsb_first accept one WIDTH-bit word;
//        ser_out/ser_valid carry the serial frame; busy spans the frame; done pulses on its final cycle.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   DIV        = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             lsb_first,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic             r_par;
  logic             w_data_end;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           r_state, w_next;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_sh, w_sh;
  logic             r_order, r_ser, r_valid;
  logic             w_tick, w_last_bit, w_accept, w_tx;
  always_comb begin
    w_tick     = r_div == DW'(DIV - 1);
    w_last_bit = r_bit == BW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
    w_data_end = r_state == SHIFT && w_tick && w_last_bit;
    done       = r_state == PARITY && w_tick;
`else
    done       = r_state == SHIFT && w_tick && w_last_bit;
`endif
    // ready only in IDLE or on the frame's final cycle, which gives gap-free back-to-back words
    in_ready   = !rst && (r_state == IDLE || done);
    w_accept   = in_valid && in_ready;
    w_next     = r_state;
    if (w_accept)
      w_next = SHIFT;
    else if (done)
      w_next = IDLE;
`ifdef PISO_PARITY_EN
    else if (w_data_end)
      w_next = PARITY;
`endif
    w_sh = r_order ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
`ifdef PISO_PARITY_EN
    w_tx = w_next == PARITY ? r_par : r_order ? w_sh[0] : w_sh[WIDTH-1];
`else
    w_tx = r_order ? w_sh[0] : w_sh[WIDTH-1];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_order <= 1'b0;
      r_ser   <= IDLE_LEVEL;
      r_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        // the output register is loaded with bit 0 now so it appears the cycle after accept
        r_sh    <= in_data;
        r_order <= lsb_first;
        r_div   <= '0;
        r_bit   <= '0;
        r_ser   <= lsb_first ? in_data[0] : in_data[WIDTH-1];
        r_valid <= 1'b1;
`ifdef PISO_PARITY_EN
        r_par   <= ^in_data;
`endif
      end else if (w_next == IDLE) begin
        r_div   <= '0;
        r_bit   <= '0;
        r_ser   <= IDLE_LEVEL;
        r_valid <= 1'b0;
      end else if (w_tick) begin
        r_div   <= '0;
        r_bit   <= r_bit + 1'b1;
        r_sh    <= w_sh;
        r_ser   <= w_tx;
      end else begin
        r_div   <= r_div + 1'b1;
      end
    end
  end
  assign ser_out   = r_ser;
  assign ser_valid = r_valid;
  assign busy      = r_valid;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of piso_serializer with WIDTH=8, DIV=4
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, lsb_first, ser_out, ser_valid, busy, done;
  logic [7:0] in_data;
  int         n_pass = 0;
  int         n_tot = 0;
  piso_serializer #(.WIDTH(8), .DIV(4), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lsb_first(lsb_first), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask
  task automatic idle_chk(input string tag);
    check({tag, "_ser_valid"}, ser_valid, 1'b0);
    check({tag, "_ser_out"}, ser_out, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask
  // Called in the first cycle after accept; returns in the first cycle after the frame.
  task automatic frame(input string tag, input logic [7:0] d, input logic lsb, input bit tog);
    for (int j = 0; j < NB * 4; j++) begin
      int   i;
      logic e;
      i = j / 4;
      if (i == 8) e = ^d;
      else e = d[lsb ? i : 7 - i];
      check({tag, "_ser_out"}, ser_out, e);
      check({tag, "_ser_valid"}, ser_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_done"}, done, j == NB * 4 - 1);
      check({tag, "_in_ready"}, in_ready, j == NB * 4 - 1);
      if (tog) begin
        lsb_first = ~lsb_first;
        in_data   = ~in_data;
      end
      step();
    end
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hC1;
    lsb_first = 1'b0;
    repeat (3) begin
      step();
      check("rst_ser_out", ser_out, 1'b0);
      check("rst_ser_valid", ser_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    frame("msb_c1", 8'hC1, 1'b0, 1'b0);
    idle_chk("msb_end");
    in_data = 8'hC1;
    lsb_first = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    frame("lsb_c1", 8'hC1, 1'b1, 1'b1);
    idle_chk("lsb_end");
    in_data = 8'hFF;
    lsb_first = 1'b0;
    in_valid = 1'b1;
    step();
    in_data = 8'h00;
    frame("b2b_ff", 8'hFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    frame("b2b_00", 8'h00, 1'b0, 1'b0);
    idle_chk("b2b_end");
    in_data = 8'hA5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (13) step();
    check("mid_ser_valid", ser_valid, 1'b1);
    check("mid_bit3", ser_out, 1'b0);
    rst = 1'b1;
    step();
    check("mid_rst_ser_valid", ser_valid, 1'b0);
    check("mid_rst_ser_out", ser_out, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    check("mid_rel_done", done, 1'b0);
    in_data = 8'h3C;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    frame("after_rst_3c", 8'h3C, 1'b0, 1'b0);
    idle_chk("after_rst_end");
`ifdef PISO_PARITY_EN
    in_data = 8'h07;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    frame("par_07", 8'h07, 1'b0, 1'b0);
    idle_chk("par_07_end");
    in_data = 8'h03;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    frame("par_03", 8'h03, 1'b0, 1'b0);
    idle_chk("par_03_end");
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out shifter: the next-generation transmit serializer for the lab datapath. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per DIV clock cycles, MSB-first or LSB-first. It generates its own bit timing internally rather than taking an external counter, and it supports gap-free back-to-back words. It sits between the word-producing logic and the serial line driver.

## Interface
- WIDTH, 8: data word width in bits; must be ≥ 2.
- DIV, 4: clock cycles per serial bit; must be ≥ 1.
- IDLE_LEVEL, 1'b0: value of ser_out when no bit is being driven.
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  in_data holds a word to send.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- lsb_first  input  1  bit order for the word, sampled at accept (0 = MSB first).
- ser_out  output  1  serial data, registered.
- ser_valid  output  1  high while ser_out carries a frame bit, registered.
- busy  output  1  high from the cycle after accept until the frame completes.
- done  output  1  one-cycle pulse on the final cycle of a frame.

## Operation
- States:
  - IDLE: in_ready=1, ser_valid=0, ser_out=IDLE_LEVEL.
  - SHIFT: data bits are driven.
  - PARITY: exists only with the macro defined.
- Accept: a word is accepted on a posedge where in_valid && in_ready.
  - On accept, in_data goes to the shift register and lsb_first to an order flag.
  - Later changes to in_data or lsb_first do not affect the word in flight.
- SHIFT:
  - ser_out = shreg[WIDTH-1] when MSB-first, shreg[0] when LSB-first.
  - A divide counter of width $clog2(DIV), or 1 bit when DIV=1, counts 0..DIV-1.
  - When the divide counter reaches DIV-1, the register shifts toward the output end and the bit counter (width $clog2(WIDTH+1)) increments.
- Frame end: the last cycle of the last bit.
  - done=1 and in_ready=1 in that cycle.
  - If a word is accepted in that cycle, its first bit follows on the next cycle with no gap, and the state stays SHIFT.
  - Otherwise the state goes to IDLE.
- in_ready is 0 in every other SHIFT/PARITY cycle. in_valid is ignored then and the producer holds its word.
- Reset (rst=1 at a posedge), including mid-frame:
  - state IDLE, counters 0, ser_out=IDLE_LEVEL, ser_valid=0, busy=0, done=0.
  - A word in flight is discarded with no done pulse.
  - in_ready is forced to 0 while rst=1.
  - in_ready is 1 on the first cycle after rst falls.

## Timing
- Accept at posedge k: bit i (i = 0..WIDTH-1) is on ser_out for cycles k+1+i·DIV through k+(i+1)·DIV.
- Latency from accept to first bit: 1 cycle.
- Frame length: WIDTH·DIV cycles (plus DIV with parity). done is high at cycle k+WIDTH·DIV.
- busy and ser_valid are high for exactly the frame's cycles. Back-to-back frames keep both continuously high.
- DIV=1: one bit per cycle, and back-to-back throughput is WIDTH bits per WIDTH cycles.
- in_valid held high in IDLE: accept occurs on the very next posedge.

## Configuration
- PISO_PARITY_EN defined:
  - After the last data bit, the block enters PARITY and drives one even-parity bit (^ of the accepted word) for DIV cycles.
  - ser_valid and busy stay high through the parity bit.
  - done and in_ready move to the parity bit's last cycle.
  - Frame length is (WIDTH+1)·DIV.
- Not defined: no PARITY state, and the frame ends after the last data bit.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → ser_out=0, ser_valid=0, busy=0, done=0, in_ready=0 during reset. First cycle after release: in_ready=1. Accept occurs on the next posedge.
- MSB-first, WIDTH=8, DIV=4, in_data=8'hC1, lsb_first=0 → ser_out 1,1,0,0,0,0,0,1, each held 4 cycles. done is a single pulse at accept+32, and ser_valid drops at accept+33.
- LSB-first, same word, lsb_first=1, with lsb_first toggled mid-frame → ser_out 1,0,0,0,0,0,1,1, unaffected by the toggle.
- Back-to-back: in_valid held with 8'hFF then 8'h00 → ser_valid high for 64 contiguous cycles. in_ready is high only at accept+32 and accept+64, and ser_out falls 1→0 exactly at accept+33.
- Reset mid-frame: assert rst during bit 3 of 8'hA5 → next cycle ser_valid=0 and ser_out=0 with no done. A following 8'h3C serializes correctly from bit 0.
- With PISO_PARITY_EN: 8'h07, DIV=4 → data bits 0,0,0,0,0,1,1,1, then parity 1 for 4 cycles. done at accept+36. With 8'h03 the parity bit is 0.
